key_event_classifier: RTL

- Consumes the debounced, active-low key level from the upstream debounce stage in the key-controlled-LED design.
- Classifies each gesture as a short press, a double click or a long press, and emits one-cycle event pulses for the downstream LED controller.
- Single clock domain, timed purely by cycle counters. The 50 MHz clock has a 20 ns period.

---
 rtl/key_event_classifier_pkg.sv | 21 ++
 rtl/key_event_classifier_if.sv | 20 ++
 rtl/key_event_classifier_edge_det.sv | 27 ++
 rtl/key_event_classifier.sv | 124 ++++++++++++
 4 files changed

// File: rtl/key_event_classifier_pkg.sv
// key_evt_pkg: shared FSM state type, default timing constants and counter-width helper
// Contents:
//   key_state_t  - classifier FSM states
//   *_CNT_DEF    - default cycle counts at 50 MHz (1 s, 300 ms, 200 ms)
//   cnt_width()  - bits needed to count up to the largest of three limits (minimum 1)
package key_evt_pkg;

    typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} key_state_t;

    localparam int LONG_CNT_DEF   = 50_000_000;
    localparam int DBL_CNT_DEF    = 15_000_000;
    localparam int REPEAT_CNT_DEF = 10_000_000;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/key_event_classifier_if.sv
// key_event_classifier_if: key level in, gesture events out
// Signals:
//   key_in       - debounced key level, 1 = released, 0 = pressed
//   short_pulse  - one-cycle single short press event
//   double_pulse - one-cycle double click event
//   long_pulse   - one-cycle long press event (and repeats when enabled)
//   pressed      - level, high while a press is in progress
// Modports: master = key source / event consumer, slave = classifier
interface key_event_classifier_if;

    logic key_in;
    logic short_pulse;
    logic double_pulse;
    logic long_pulse;
    logic pressed;

    modport master (output key_in, input short_pulse, double_pulse, long_pulse, pressed);
    modport slave  (input key_in, output short_pulse, double_pulse, long_pulse, pressed);

endinterface

// File: rtl/key_event_classifier_edge_det.sv
// key_edge_det: registers the key level and strobes its falling and rising edges
// Ports:
//   clk, rstn - clock and asynchronous active-low reset
//   i_key     - debounced key level (1 = released)
//   o_fall    - high in the cycle the key is first seen pressed
//   o_rise    - high in the cycle the key is first seen released
module key_edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic i_key,
    output logic o_fall,
    output logic o_rise
);

    logic r_key;

    // Reset to the released level so a key already held at reset release reads as a press.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) r_key <= 1'b1;
        else       r_key <= i_key;

    // Strobes compare the live level with the registered one, so they coincide with the
    // first sampling edge of the new level and add no latency to the FSM.
    assign o_fall = r_key & ~i_key;
    assign o_rise = ~r_key & i_key;

endmodule

// File: rtl/key_event_classifier.sv
// key_event_classifier: classifies key gestures into short, double and long press pulses
// Ports:
//   clk  - system clock (50 MHz)
//   rstn - asynchronous active-low reset
//   bus  - key_event_classifier_if.slave (key_in in; short/double/long pulses and pressed out)
// Optional feature: define KEY_LONG_REPEAT_EN for long_pulse auto-repeat every REPEAT_CNT
// cycles while the key stays held in LONG.
module key_event_classifier
    import key_evt_pkg::*;
#(
    parameter int LONG_CNT   = LONG_CNT_DEF,
    parameter int DBL_CNT    = DBL_CNT_DEF,
    parameter int REPEAT_CNT = REPEAT_CNT_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    key_event_classifier_if.slave  bus
);

    localparam int CW = cnt_width(LONG_CNT, DBL_CNT, REPEAT_CNT);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
    localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_CNT - 1);
`ifdef KEY_LONG_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CNT - 1);
`endif

    key_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_short;
    logic          r_double;
    logic          r_long;
    logic          r_pressed;
    logic          w_fall;
    logic          w_rise;
    logic [CW-1:0] w_cnt_inc;

    key_edge_det u_edge (
        .clk    (clk),
        .rstn   (rstn),
        .i_key  (bus.key_in),
        .o_fall (w_fall),
        .o_rise (w_rise)
    );

    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    // The edge strobes are exact here: IDLE/WAIT2 are only ever occupied with the key
    // released and PRESS1/PRESS2/LONG with it pressed. Release/press checks come before the
    // terminal-count checks so the key wins a tie with the counter.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_short   <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            case (r_state)
                IDLE:
                    if (w_fall) begin
                        r_state   <= PRESS1;
                        r_cnt     <= '0;
                        r_pressed <= 1'b1;
                    end
                PRESS1:
                    if (w_rise) begin
                        r_state   <= WAIT2;
                        r_cnt     <= '0;
                        r_pressed <= 1'b0;
                    end else if (r_cnt == LONG_LAST) begin
                        r_state <= LONG;
                        r_cnt   <= '0;
                        r_long  <= 1'b1;
                    end else
                        r_cnt <= w_cnt_inc;
                WAIT2:
                    if (w_fall) begin
                        r_state   <= PRESS2;
                        r_cnt     <= '0;
                        r_double  <= 1'b1;
                        r_pressed <= 1'b1;
                    end else if (r_cnt == DBL_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_short <= 1'b1;
                    end else
                        r_cnt <= w_cnt_inc;
                PRESS2:
                    if (w_rise) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_pressed <= 1'b0;
                    end
                LONG:
                    if (w_rise) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_pressed <= 1'b0;
                    end
`ifdef KEY_LONG_REPEAT_EN
                    else if (r_cnt == REP_LAST) begin
                        r_cnt  <= '0;
                        r_long <= 1'b1;
                    end else
                        r_cnt <= w_cnt_inc;
`endif
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    r_pressed <= 1'b0;
                end
            endcase
        end

    assign bus.short_pulse  = r_short;
    assign bus.double_pulse = r_double;
    assign bus.long_pulse   = r_long;
    assign bus.pressed      = r_pressed;

endmodule
